// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, delta codes and Gray decode for gray_decoder
package gray_pkg;

    typedef enum logic [1:0] {
        A = 2'b00,
        B = 2'b01,
        C = 2'b10,
        D = 2'b11
    } gray_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } dec_state_t;

    localparam logic [1:0] D_NONE = 2'd0;
    localparam logic [1:0] D_FWD  = 2'd1;
    localparam logic [1:0] D_ILL  = 2'd2;
    localparam logic [1:0] D_BWD  = 2'd3;

    function automatic logic [1:0] gray2bin(input logic [1:0] gv);
        return {gv[1], gv[1] ^ gv[0]};
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-stage 2-bit synchroniser with async active-low clear
module gray_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] stage [SYNC_STAGES];

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= 2'b00;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - 2-bit Gray/quadrature decoder driving a wrapping position counter
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [1:0]       g,
    input  logic             enable,
    input  logic             zero,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pos,
    output logic [1:0]       bin,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_sticky
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    dec_state_t       state;
    dec_state_t       next_state;
    logic [CNT_W-1:0] init_cnt;
    logic [1:0]       g_sync;
    logic [1:0]       bin_now;
    logic [1:0]       bin_prev;
    logic [1:0]       delta;
    logic             cnt_inc;
    logic             load_prev;
    logic             fwd;
    logic             bwd;
    logic             ill;

    gray_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .clear_n(clear_n),
        .d      (g),
        .q      (g_sync)
    );

    assign bin_now = gray2bin(g_sync);
    assign bin     = bin_now;
    assign delta   = bin_now - bin_prev;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // INIT holds one extra cycle past the sync fill so the first compare sees a settled bin_prev
    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        load_prev  = 1'b0;
        fwd        = 1'b0;
        bwd        = 1'b0;
        ill        = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == CNT_W'(SYNC_STAGES)) begin
                    next_state = TRACK;
                    load_prev  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            TRACK: begin
                load_prev = 1'b1;
                if (enable) begin
                    case (delta)
                        D_FWD:   fwd = 1'b1;
                        D_BWD:   bwd = 1'b1;
                        D_ILL:   ill = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            init_cnt <= '0;
            bin_prev <= 2'b00;
        end else begin
            if (cnt_inc) begin
                init_cnt <= init_cnt + CNT_W'(1);
            end
            if (load_prev) begin
                bin_prev <= bin_now;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pos        <= '0;
            dir        <= 1'b1;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (zero) begin
                pos <= '0;
            end else if (fwd) begin
                pos <= pos + WIDTH'(1);
            end else if (bwd) begin
                pos <= pos - WIDTH'(1);
            end
            if (fwd) begin
                dir <= 1'b1;
            end else if (bwd) begin
                dir <= 1'b0;
            end
            step <= fwd | bwd;
            err  <= ill;
            // a fresh error outranks a same-cycle clear request
            if (ill) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - scoreboard bench for gray_decoder
module tb_gray_decoder;

    logic       clock = 1'b0;
    logic       clear_n;
    logic [1:0] g;
    logic       enable;
    logic       zero;
    logic       err_clr;
    logic [7:0] pos;
    logic [1:0] bin;
    logic       dir;
    logic       step;
    logic       err;
    logic       err_sticky;

    typedef struct {
        int         cyc;
        logic       is_err;
        logic [7:0] pos;
        logic       dir;
    } ev_t;

    ev_t        sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         step_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_g;
    logic [7:0] model_pos;
    logic       model_dir;
    logic       model_sticky;

    gray_decoder #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .g         (g),
        .enable    (enable),
        .zero      (zero),
        .err_clr   (err_clr),
        .pos       (pos),
        .bin       (bin),
        .dir       (dir),
        .step      (step),
        .err       (err),
        .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int tb_decode(input logic [1:0] gv);
        case (gv)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // drive a new Gray value at a falling edge and push the event expected three edges later
    task automatic drive_g(input logic [1:0] nv, input bit zero_hit);
        int d;
        g = nv;
        d = (tb_decode(nv) - tb_decode(last_g)) & 3;
        last_g = nv;
        if (enable) begin
            if (d == 1 || d == 3) begin
                model_pos = (d == 1) ? model_pos + 8'd1 : model_pos - 8'd1;
                if (zero_hit) model_pos = 8'd0;
                model_dir = (d == 1);
                sb.push_back('{cyc: cyc + 3, is_err: 1'b0, pos: model_pos, dir: model_dir});
            end else if (d == 2) begin
                model_sticky = 1'b1;
                sb.push_back('{cyc: cyc + 3, is_err: 1'b1, pos: model_pos, dir: model_dir});
            end
        end
    endtask

    always @(negedge clock) begin
        ev_t e;
        if (step && err) check_eq("step_err_overlap", 32'd1, 32'd0);
        if (step) step_cnt++;
        if (err) err_cnt++;
        if (step || err) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_event", {30'd0, step, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("evt_cycle", cyc, e.cyc);
                check_eq("evt_kind_err", {31'd0, err}, {31'd0, e.is_err});
                check_eq("evt_pos", {24'd0, pos}, {24'd0, e.pos});
                check_eq("evt_dir", {31'd0, dir}, {31'd0, e.dir});
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_eq("missed_event_at", cyc, 32'hFFFF_FFFF);
        end
    end

    initial begin
        int s0;
        clear_n      = 1'b0;
        g            = 2'b00;
        enable       = 1'b1;
        zero         = 1'b0;
        err_clr      = 1'b0;
        last_g       = 2'b00;
        model_pos    = 8'd0;
        model_dir    = 1'b1;
        model_sticky = 1'b0;

        tick(1);
        check_eq("rst_pos", {24'd0, pos}, 32'd0);
        check_eq("rst_bin", {30'd0, bin}, 32'd0);
        check_eq("rst_dir", {31'd0, dir}, 32'd1);
        check_eq("rst_step", {31'd0, step}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_sticky", {31'd0, err_sticky}, 32'd0);
        clear_n = 1'b1;
        tick(5);

        // forward cycle with input latency check on bin
        s0 = step_cnt;
        drive_g(2'b01, 1'b0);
        tick(1);
        check_eq("bin_latency_old", {30'd0, bin}, 32'd0);
        tick(1);
        check_eq("bin_latency_new", {30'd0, bin}, 32'd1);
        tick(2);
        drive_g(2'b11, 1'b0); tick(4);
        drive_g(2'b10, 1'b0); tick(4);
        drive_g(2'b00, 1'b0); tick(4);
        check_eq("fwd_steps", step_cnt - s0, 32'd4);
        check_eq("fwd_pos", {24'd0, pos}, 32'd4);
        check_eq("fwd_dir", {31'd0, dir}, 32'd1);
        check_eq("fwd_sticky", {31'd0, err_sticky}, 32'd0);

        // backward through zero
        zero = 1'b1; tick(1); zero = 1'b0; model_pos = 8'd0;
        check_eq("zero_pos", {24'd0, pos}, 32'd0);
        drive_g(2'b10, 1'b0); tick(4);
        drive_g(2'b11, 1'b0); tick(4);
        check_eq("bwd_pos", {24'd0, pos}, 32'hFE);
        check_eq("bwd_dir", {31'd0, dir}, 32'd0);

        // illegal jump then resync
        drive_g(2'b10, 1'b0); tick(4);
        drive_g(2'b00, 1'b0); tick(4);
        drive_g(2'b11, 1'b0); tick(4);
        check_eq("ill_pos", {24'd0, pos}, 32'd0);
        check_eq("ill_sticky", {31'd0, err_sticky}, 32'd1);
        drive_g(2'b10, 1'b0); tick(4);
        check_eq("resync_pos", {24'd0, pos}, 32'd1);
        check_eq("resync_sticky", {31'd0, err_sticky}, 32'd1);

        // disabled tracking leaves no backlog
        s0 = err_cnt;
        enable = 1'b0;
        tick(1);
        drive_g(2'b00, 1'b0); tick(4);
        drive_g(2'b01, 1'b0); tick(4);
        drive_g(2'b11, 1'b0); tick(4);
        check_eq("dis_pos_hold", {24'd0, pos}, 32'd1);
        enable = 1'b1;
        tick(1);
        drive_g(2'b10, 1'b0); tick(4);
        check_eq("en_pos", {24'd0, pos}, 32'd2);
        check_eq("en_no_err", err_cnt - s0, 32'd0);

        // err_clr alone, then err_clr colliding with a new error
        err_clr = 1'b1; tick(1); err_clr = 1'b0; model_sticky = 1'b0;
        check_eq("clr_sticky", {31'd0, err_sticky}, 32'd0);
        drive_g(2'b01, 1'b0);
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_eq("clr_vs_err_sticky", {31'd0, err_sticky}, {31'd0, model_sticky});
        tick(2);

        // zero coinciding with a forward step
        drive_g(2'b11, 1'b1);
        tick(2);
        zero = 1'b1;
        tick(1);
        zero = 1'b0;
        check_eq("zero_step_pos", {24'd0, pos}, 32'd0);
        check_eq("zero_step_pulse", {31'd0, step}, 32'd1);
        tick(2);

        // walk to pos=5 then reset mid-transition
        drive_g(2'b10, 1'b0); tick(4);
        drive_g(2'b00, 1'b0); tick(4);
        drive_g(2'b01, 1'b0); tick(4);
        drive_g(2'b11, 1'b0); tick(4);
        drive_g(2'b10, 1'b0); tick(4);
        check_eq("pre_rst_pos", {24'd0, pos}, 32'd5);
        g = 2'b00;
        tick(1);
        #2 clear_n = 1'b0;
        sb.delete();
        #1;
        check_eq("arst_pos", {24'd0, pos}, 32'd0);
        check_eq("arst_bin", {30'd0, bin}, 32'd0);
        check_eq("arst_dir", {31'd0, dir}, 32'd1);
        check_eq("arst_step", {31'd0, step}, 32'd0);
        check_eq("arst_err", {31'd0, err}, 32'd0);
        check_eq("arst_sticky", {31'd0, err_sticky}, 32'd0);
        model_pos = 8'd0; model_dir = 1'b1; model_sticky = 1'b0;
        tick(1);
        g = 2'b11;
        last_g = 2'b11;
        tick(2);
        s0 = step_cnt;
        clear_n = 1'b1;
        tick(6);
        check_eq("post_rst_no_step", step_cnt - s0, 32'd0);
        check_eq("post_rst_pos", {24'd0, pos}, 32'd0);
        drive_g(2'b10, 1'b0); tick(4);
        check_eq("post_rst_fwd_pos", {24'd0, pos}, 32'd1);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
